// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   DEF_FIFO_WIDTH : default beat data width
//   DEF_BUF_DEPTH  : default output buffer depth
//   DEF_CNT_W      : default delivered-beat counter width
//   stream_beat_t  : one valid/data stream beat, reusable by drivers and monitors
package fifo_stream_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 32;
    localparam int unsigned DEF_BUF_DEPTH  = 3;
    localparam int unsigned DEF_CNT_W      = 16;

    typedef struct packed {
        logic                      valid;
        logic [DEF_FIFO_WIDTH-1:0] data;
    } stream_beat_t;

endpackage

// File: rtl/fifo_drain_buf.sv
// Circular output buffer for the FIFO drain stream.
//   clk, rstN   : clock, asynchronous active-low reset
//   push        : write push_data at the write pointer (caller guarantees space)
//   push_data   : data to store
//   pop         : release the head entry (caller guarantees occ != 0)
//   flush       : discard all contents and rewind both pointers
//   occ         : registered occupancy
//   occ_next_c  : combinational occupancy after this cycle's push/pop/flush
//   head        : registered copy of the entry at the read pointer
module fifo_drain_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned DEPTH = DEF_BUF_DEPTH,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [LVL_W-1:0] occ,
    output logic [LVL_W-1:0] occ_next_c,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [WIDTH-1:0] head_next;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointer / occupancy state.
    always_comb begin
        occ_next_c  = occ;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (flush) begin
            occ_next_c  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) wr_ptr_next = ptr_inc(wr_ptr);
            if (pop)  rd_ptr_next = ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ_next_c = occ + LVL_W'(1);
                2'b01:   occ_next_c = occ - LVL_W'(1);
                default: occ_next_c = occ;
            endcase
        end
    end

    // Next head: a push landing in the slot that becomes head bypasses the array.
    always_comb begin
        head_next = head;
        if (!flush) begin
            if (push && (wr_ptr == rd_ptr_next)) head_next = push_data;
            else                                 head_next = mem[rd_ptr_next];
        end
    end

    // Storage array; contents are only observed through the reset head register.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    // Control state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            occ    <= occ_next_c;
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            head   <= head_next;
        end
    end

endmodule

// File: rtl/fifo_drain_stream.sv
// Read-side consumer of a synchronous FIFO, presenting a valid/ready stream.
// A credit check on the output buffer hides the FIFO's one-cycle read latency.
//   clk, rstN      : clock, asynchronous active-low reset
//   fifo_empty     : FIFO empty flag
//   fifo_data_out  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en     : FIFO read enable (registered)
//   flush          : synchronous discard of buffered and in-flight data
//   m_valid/m_ready/m_data : output stream
//   buf_level      : output buffer occupancy
//   beat_cnt       : completed handshakes, wrapping
module fifo_drain_stream
    import fifo_stream_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           fifo_empty,
    input  logic [FIFO_WIDTH-1:0]          fifo_data_out,
    output logic                           fifo_rd_en,
    input  logic                           flush,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [FIFO_WIDTH-1:0]          m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_level,
    output logic [CNT_W-1:0]               beat_cnt
);

    localparam int unsigned LVL_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = LVL_W + 1;

    logic             inflight;
    logic             drop;
    logic             capture_c;
    logic             pop_c;
    logic             rd_en_next_c;
    logic [LVL_W-1:0] occ;
    logic [LVL_W-1:0] occ_next_c;

    // A beat returning during a flush, or from a read issued in the flush cycle, is discarded.
    assign capture_c = inflight && !drop && !flush;
    assign pop_c     = m_valid && m_ready;
    assign buf_level = occ;

    fifo_drain_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH),
        .LVL_W (LVL_W)
    ) u_buf (
        .clk        (clk),
        .rstN       (rstN),
        .push       (capture_c),
        .push_data  (fifo_data_out),
        .pop        (pop_c),
        .flush      (flush),
        .occ        (occ),
        .occ_next_c (occ_next_c),
        .head       (m_data)
    );

    // Issue only if the slot is guaranteed: next occupancy plus the read now in flight.
    // m_ready reaches this only through occ_next_c, which feeds a register.
    always_comb begin
        rd_en_next_c = 1'b0;
        if (!fifo_empty && !flush &&
            ((SUM_W'(occ_next_c) + SUM_W'(fifo_rd_en)) < SUM_W'(BUF_DEPTH))) begin
            rd_en_next_c = 1'b1;
        end
    end

    // Read issue, in-flight tracking, valid and handshake counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fifo_rd_en <= 1'b0;
            inflight   <= 1'b0;
            drop       <= 1'b0;
            m_valid    <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            fifo_rd_en <= rd_en_next_c;
            inflight   <= fifo_rd_en;
            drop       <= flush && fifo_rd_en;
            m_valid    <= (occ_next_c != '0);
            if (pop_c) beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_drain_stream.sv
// Scoreboard bench for fifo_drain_stream: a FIFO model feeds the DUT, stimulus
// queues the beats that must come out, a negedge monitor pops and compares.
module tb_fifo_drain_stream;
    import fifo_stream_pkg::*;

    localparam int unsigned W     = DEF_FIFO_WIDTH;
    localparam int unsigned DEPTH = DEF_BUF_DEPTH;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [LW-1:0] buf_level;
    logic [CW-1:0] beat_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_drain_stream #(
        .FIFO_WIDTH (W),
        .BUF_DEPTH  (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .buf_level     (buf_level),
        .beat_cnt      (beat_cnt)
    );

    // FIFO model. Its empty flag already accounts for the read accepted this cycle.
    logic [W-1:0] src_mem [256];
    int           src_wr = 0;
    int           src_rd = 0;
    int           rd_pulses = 0;

    assign fifo_empty = (src_wr == src_rd) || (((src_wr - src_rd) == 1) && fifo_rd_en);

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            src_rd        <= src_wr;
            fifo_data_out <= '0;
        end else if (fifo_rd_en) begin
            if (src_rd < src_wr) begin
                fifo_data_out <= src_mem[src_rd];
                src_rd        <= src_rd + 1;
            end
            rd_pulses <= rd_pulses + 1;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and stream-rule monitor.
    logic [W-1:0] exp_q[$];
    stream_beat_t obs;
    logic [W-1:0] exp_word;
    bit           stall_prev = 1'b0;
    logic [W-1:0] stall_data;

    always @(negedge clk) begin
        if (!rstN) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, stall_data);
            end
            stall_prev = m_valid && !m_ready && !flush;
            stall_data = m_data;
            if (m_valid && m_ready) begin
                obs.valid = m_valid;
                obs.data  = m_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", obs.data, ~obs.data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("beat_data", obs.data, exp_word);
                end
            end
            if (fifo_rd_en) check("no_underflow", W'(src_wr > src_rd), 1);
            if (buf_level == LW'(DEPTH)) check("rd_en_low_when_full", fifo_rd_en, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d, input bit expect_out);
        src_mem[src_wr] = d;
        src_wr = src_wr + 1;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic wait_drain(input int max);
        for (int k = 0; k < max; k++) begin
            if (exp_q.size() == 0 && !m_valid) break;
            tick();
        end
        check("drain_done", W'(exp_q.size() == 0 && !m_valid), 1);
    endtask

    int n;
    int hi;
    int peak;
    int p0;
    logic [CW-1:0] cnt_before;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_buf_level", buf_level, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        rstN = 1'b1;
        tick();

        // Latency and back-to-back streaming
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(W'(i), 1'b1);
        n = 0;
        do begin tick(); n++; end while (!fifo_rd_en && n < 10);
        check("rd_en_latency", n, 1);
        n = 0;
        do begin tick(); n++; end while (!m_valid && n < 10);
        check("valid_latency", n, 2);
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_valid) hi++;
            tick();
        end
        check("back_to_back", hi, 8);
        check("valid_after_stream", m_valid, 0);
        check("beat_cnt_8", beat_cnt, 8);

        // Backpressure
        m_ready = 1'b0;
        p0 = rd_pulses;
        for (int i = 1; i <= 8; i++) push_word(W'(32'h10 + i), 1'b1);
        peak = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (int'(buf_level) > peak) peak = int'(buf_level);
        end
        check("peak_level", peak, DEPTH);
        check("rd_en_stalled", fifo_rd_en, 0);
        m_ready = 1'b1;
        wait_drain(50);
        check("bp_reads", rd_pulses - p0, 8);

        // Empty boundary: two words, two reads
        p0 = rd_pulses;
        cnt_before = beat_cnt;
        push_word(32'hA5A5_A5A5, 1'b1);
        push_word(32'h5A5A_5A5A, 1'b1);
        wait_drain(20);
        tick();
        check("two_reads", rd_pulses - p0, 2);
        check("two_beats", beat_cnt, CW'(cnt_before + 2));
        check("valid_low_after_two", m_valid, 0);

        // Flush with a read in flight and occ=1
        m_ready = 1'b0;
        push_word(32'hF0, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!m_valid && n < 10);
        push_word(32'hF1, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!fifo_rd_en && n < 10);
        check("flush_setup_rd_en", fifo_rd_en, 1);
        cnt_before = beat_cnt;
        tick();
        flush = 1'b1;
        check("flush_setup_occ", buf_level, 1);
        tick();
        flush = 1'b0;
        check("flush_level", buf_level, 0);
        check("flush_valid", m_valid, 0);
        check("flush_rd_en", fifo_rd_en, 0);
        check("flush_cnt", beat_cnt, cnt_before);
        tick();
        tick();
        check("flush_discard", buf_level, 0);
        push_word(32'hF2, 1'b1);
        m_ready = 1'b1;
        wait_drain(20);

        // Asynchronous reset mid-stream with occ=2
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(W'(32'h60 + i), 1'b0);
        n = 0;
        do begin tick(); n++; end while (buf_level != LW'(2) && n < 10);
        check("rst_setup_occ", buf_level, 2);
        #2;
        rstN = 1'b0;
        #1;
        check("arst_rd_en", fifo_rd_en, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_m_data", m_data, 0);
        check("arst_buf_level", buf_level, 0);
        check("arst_beat_cnt", beat_cnt, 0);
        tick();
        tick();
        rstN = 1'b1;
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (fifo_rd_en) hi++;
        end
        check("idle_no_reads", hi, 0);
        m_ready = 1'b1;
        push_word(32'h77, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!fifo_rd_en && n < 10);
        check("post_rst_rd_latency", n, 1);
        wait_drain(20);

        // Counter wrap: 17 handshakes from reset on a 4-bit counter
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) push_word(W'(32'h100 + i), 1'b1);
        wait_drain(60);
        check("beat_cnt_wrap", beat_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
